// File: rtl/instr_fetch_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
interface instr_fetch_if;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;

    modport master (
        output imem_req_o,
        output imem_addr_o,
        input  imem_ack_i,
        input  imem_rdata_i
    );

    modport slave (
        input  imem_req_o,
        input  imem_addr_o,
        output imem_ack_i,
        output imem_rdata_i
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: IDLE/FETCH/HOLD/DRAIN request FSM feeding IF/ID.
// Optional performance counters are built only when FETCH_PERF_CNT_EN is defined.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 stall_i,
    input  logic                 branch_i,
    input  logic [31:0]          branch_target_i,
    instr_fetch_if.master        imem,
    output logic [31:0]          inst_o,
    output logic [31:0]          pc_o,
    output logic                 inst_valid_o,
    output logic                 flush_o,
    output logic [31:0]          fetch_cnt_o,
    output logic [31:0]          bubble_cnt_o
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] drain_addr_q, drain_addr_d;
    logic [31:0] hold_inst_q, hold_pc_q;
    logic        hold_load;
    logic        load_valid, load_bubble;
    logic [31:0] load_inst, load_pc;
    logic        req;
    logic [31:0] req_addr;
    logic [31:0] target;
    logic [31:0] pc_inc;
    logic        ack;

    assign target  = {branch_target_i[31:2], 2'b00};
    assign pc_inc  = pc_q + 32'd4;
    assign ack     = imem.imem_ack_i;
    assign flush_o = branch_i;

    assign imem.imem_req_o  = req;
    assign imem.imem_addr_o = req_addr;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            drain_addr_q <= 32'h0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drain_addr_d = drain_addr_q;
        hold_load    = 1'b0;
        load_valid   = 1'b0;
        load_inst    = hold_inst_q;
        load_pc      = hold_pc_q;
        req          = 1'b0;
        req_addr     = pc_q;
        case (state_q)
            IDLE: begin
                state_d = FETCH;
                if (branch_i) pc_d = target;
            end
            FETCH: begin
                req = 1'b1;
                if (branch_i) begin
                    // An un-acked request cannot be retracted; drain it at the old address.
                    pc_d = target;
                    if (!ack) begin
                        state_d      = DRAIN;
                        drain_addr_d = pc_q;
                    end
                end else if (ack) begin
                    if (stall_i) begin
                        hold_load = 1'b1;
                        state_d   = HOLD;
                    end else begin
                        load_valid = 1'b1;
                        load_inst  = imem.imem_rdata_i;
                        load_pc    = pc_q;
                        pc_d       = pc_inc;
                    end
                end
            end
            HOLD: begin
                if (branch_i) begin
                    pc_d    = target;
                    state_d = FETCH;
                end else if (!stall_i) begin
                    load_valid = 1'b1;
                    pc_d       = pc_inc;
                    state_d    = FETCH;
                end
            end
            DRAIN: begin
                req      = 1'b1;
                req_addr = drain_addr_q;
                if (branch_i) pc_d = target;
                if (ack) state_d = FETCH;
            end
            default: state_d = IDLE;
        endcase
    end

    // A branch always injects a bubble, even under stall.
    assign load_bubble = branch_i || (!stall_i && !load_valid);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hold_inst_q <= 32'h0;
            hold_pc_q   <= 32'h0;
        end else if (hold_load) begin
            hold_inst_q <= imem.imem_rdata_i;
            hold_pc_q   <= pc_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            inst_o       <= 32'h0;
            pc_o         <= 32'h0;
            inst_valid_o <= 1'b0;
        end else if (load_bubble) begin
            inst_o       <= 32'h0;
            inst_valid_o <= 1'b0;
        end else if (load_valid) begin
            inst_o       <= load_inst;
            pc_o         <= load_pc;
            inst_valid_o <= 1'b1;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fetch_cnt_o  <= 32'h0;
            bubble_cnt_o <= 32'h0;
        end else begin
            if (load_bubble)     bubble_cnt_o <= bubble_cnt_o + 32'd1;
            else if (load_valid) fetch_cnt_o  <= fetch_cnt_o + 32'd1;
        end
    end
`else
    assign fetch_cnt_o  = 32'h0;
    assign bubble_cnt_o = 32'h0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus random traffic vs a transaction model.
module tb_instr_fetch;
    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        stall_i = 1'b0;
    logic        branch_i = 1'b0;
    logic [31:0] branch_target_i = 32'h0;
    logic [31:0] inst_o, pc_o, fetch_cnt_o, bubble_cnt_o;
    logic        inst_valid_o, flush_o;

    int n_tests = 0;
    int n_fail  = 0;

    instr_fetch_if bus ();

    instr_fetch #(.RESET_PC(RST_PC)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .stall_i         (stall_i),
        .branch_i        (branch_i),
        .branch_target_i (branch_target_i),
        .imem            (bus),
        .inst_o          (inst_o),
        .pc_o            (pc_o),
        .inst_valid_o    (inst_valid_o),
        .flush_o         (flush_o),
        .fetch_cnt_o     (fetch_cnt_o),
        .bubble_cnt_o    (bubble_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    assign bus.imem_rdata_i = mem(bus.imem_addr_o);

    // Reference model: one outstanding request, an optional held instruction,
    // and a flag marking the outstanding request as stale after a redirect.
    logic [31:0] m_pc, m_req_addr, m_held_inst, m_held_pc;
    logic        m_req, m_stale, m_held;
    logic [31:0] m_inst, m_pcq;
    logic        m_valid;
    logic [31:0] m_fc, m_bc;

    task automatic model_reset();
        m_pc = RST_PC; m_req_addr = RST_PC; m_req = 0; m_stale = 0; m_held = 0;
        m_held_inst = 0; m_held_pc = 0;
        m_inst = 0; m_pcq = 0; m_valid = 0; m_fc = 0; m_bc = 0;
    endtask

    task automatic m_bubble();
        m_inst = 0; m_valid = 0; m_bc = m_bc + 1;
    endtask

    task automatic m_deliver(input logic [31:0] d, input logic [31:0] pa);
        m_inst = d; m_pcq = pa; m_valid = 1; m_fc = m_fc + 1;
    endtask

    task automatic model_step(input logic s, input logic b, input logic [31:0] t, input logic a);
        logic        got;
        logic [31:0] data;
        got  = m_req && a;
        data = mem(m_req_addr);
        if (b) begin
            m_bubble();
            m_held = 0;
            m_pc = {t[31:2], 2'b00};
            if (m_req && !got) m_stale = 1;
            else begin m_req = 1; m_stale = 0; m_req_addr = m_pc; end
        end else if (got && m_stale) begin
            m_stale = 0; m_req_addr = m_pc;
            if (!s) m_bubble();
        end else if (got) begin
            if (s) begin
                m_held = 1; m_held_inst = data; m_held_pc = m_req_addr; m_req = 0;
            end else begin
                m_deliver(data, m_req_addr);
                m_pc = m_pc + 32'd4; m_req_addr = m_pc;
            end
        end else if (m_held) begin
            if (!s) begin
                m_deliver(m_held_inst, m_held_pc);
                m_held = 0; m_pc = m_pc + 32'd4; m_req = 1; m_req_addr = m_pc;
            end
        end else begin
            if (!m_req) begin m_req = 1; m_req_addr = m_pc; end
            if (!s) m_bubble();
        end
    endtask

    task automatic tick(input logic s, input logic b, input logic [31:0] t, input logic a);
        stall_i = s; branch_i = b; branch_target_i = t; bus.imem_ack_i = a;
        @(posedge clk_i);
        model_step(s, b, t, a);
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        stall_i = 0; branch_i = 0; bus.imem_ack_i = 0;
        rst_i = 1;
        model_reset();
        @(negedge clk_i);
        rst_i = 0;
    endtask

    task automatic test_reset();
        bus.imem_ack_i = 1;
        model_reset();
        #2;
        n_tests++; if (bus.imem_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b want 0", bus.imem_req_o); end
        n_tests++; if (inst_o !== 32'h0) begin n_fail++; $display("FAIL reset_inst got %h want 0", inst_o); end
        n_tests++; if (pc_o !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h want 0", pc_o); end
        n_tests++; if (inst_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", inst_valid_o); end
        n_tests++; if (fetch_cnt_o !== 32'h0 || bubble_cnt_o !== 32'h0) begin n_fail++; $display("FAIL reset_cnt got %0d/%0d want 0/0", fetch_cnt_o, bubble_cnt_o); end
        do_reset();
        tick(0, 0, 0, 1);
        n_tests++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== RST_PC) begin n_fail++; $display("FAIL first_req got %b/%h want 1/%h", bus.imem_req_o, bus.imem_addr_o, RST_PC); end
        n_tests++; if (inst_valid_o !== 1'b0) begin n_fail++; $display("FAIL idle_ack_ignored valid got %b want 0", inst_valid_o); end
    endtask

    task automatic test_zero_wait();
        do_reset();
        tick(0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            tick(0, 0, 0, 1);
            n_tests++; if (pc_o !== RST_PC + 4*k || inst_valid_o !== 1'b1 || inst_o !== mem(RST_PC + 4*k)) begin
                n_fail++; $display("FAIL zero_wait[%0d] got pc %h v %b inst %h want pc %h v 1 inst %h", k, pc_o, inst_valid_o, inst_o, RST_PC + 4*k, mem(RST_PC + 4*k));
            end
        end
    endtask

    task automatic test_wait_states();
        do_reset();
        tick(0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            for (int w = 0; w < 2; w++) begin
                tick(0, 0, 0, 0);
                n_tests++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== RST_PC + 4*k || inst_valid_o !== 1'b0) begin
                    n_fail++; $display("FAIL wait_state[%0d.%0d] got req %b addr %h v %b want 1 %h 0", k, w, bus.imem_req_o, bus.imem_addr_o, inst_valid_o, RST_PC + 4*k);
                end
            end
            tick(0, 0, 0, 1);
            n_tests++; if (pc_o !== RST_PC + 4*k || inst_valid_o !== 1'b1) begin
                n_fail++; $display("FAIL wait_deliver[%0d] got %h/%b want %h/1", k, pc_o, inst_valid_o, RST_PC + 4*k);
            end
        end
    endtask

    task automatic test_stall_hold();
        do_reset();
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 1);
        tick(1, 0, 0, 1);
        for (int k = 0; k < 2; k++) begin
            n_tests++; if (pc_o !== RST_PC || inst_valid_o !== 1'b1 || bus.imem_req_o !== 1'b0) begin
                n_fail++; $display("FAIL stall_frozen[%0d] got pc %h v %b req %b want %h 1 0", k, pc_o, inst_valid_o, bus.imem_req_o, RST_PC);
            end
            tick(1, 0, 0, 0);
        end
        n_tests++; if (pc_o !== RST_PC || inst_valid_o !== 1'b1) begin n_fail++; $display("FAIL stall_frozen_end got %h/%b want %h/1", pc_o, inst_valid_o, RST_PC); end
        tick(0, 0, 0, 0);
        n_tests++; if (pc_o !== RST_PC + 4 || inst_o !== mem(RST_PC + 4) || inst_valid_o !== 1'b1) begin
            n_fail++; $display("FAIL stall_release got pc %h inst %h want %h %h", pc_o, inst_o, RST_PC + 4, mem(RST_PC + 4));
        end
        tick(0, 0, 0, 1);
        n_tests++; if (pc_o !== RST_PC + 8 || inst_valid_o !== 1'b1) begin n_fail++; $display("FAIL stall_next got %h want %h", pc_o, RST_PC + 8); end
    endtask

    task automatic test_branch_drain();
        do_reset();
        tick(0, 0, 0, 0);
        stall_i = 0; branch_i = 1; branch_target_i = 32'h2003; bus.imem_ack_i = 0;
        #1;
        n_tests++; if (flush_o !== 1'b1) begin n_fail++; $display("FAIL flush got %b want 1", flush_o); end
        tick(0, 1, 32'h2003, 0);
        n_tests++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== RST_PC) begin n_fail++; $display("FAIL drain_addr got %b/%h want 1/%h", bus.imem_req_o, bus.imem_addr_o, RST_PC); end
        tick(0, 0, 0, 0);
        n_tests++; if (bus.imem_addr_o !== RST_PC || inst_valid_o !== 1'b0) begin n_fail++; $display("FAIL drain_wait got %h/%b want %h/0", bus.imem_addr_o, inst_valid_o, RST_PC); end
        tick(0, 0, 0, 1);
        n_tests++; if (inst_valid_o !== 1'b0 || bus.imem_addr_o !== 32'h2000) begin n_fail++; $display("FAIL drain_discard got v %b addr %h want 0 2000", inst_valid_o, bus.imem_addr_o); end
        tick(0, 0, 0, 1);
        n_tests++; if (pc_o !== 32'h2000 || inst_valid_o !== 1'b1) begin n_fail++; $display("FAIL branch_target got %h/%b want 2000/1", pc_o, inst_valid_o); end
    endtask

    task automatic test_wrap_and_async_reset();
        do_reset();
        tick(0, 0, 0, 0);
        tick(0, 1, 32'hFFFF_FFFC, 1);
        n_tests++; if (bus.imem_addr_o !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_pre got %h want fffffffc", bus.imem_addr_o); end
        tick(0, 0, 0, 1);
        n_tests++; if (pc_o !== 32'hFFFF_FFFC || bus.imem_addr_o !== 32'h0) begin n_fail++; $display("FAIL wrap got pc %h addr %h want fffffffc 0", pc_o, bus.imem_addr_o); end
        tick(0, 1, 32'hFFFF_FFFC, 1);
        tick(0, 0, 0, 0);
        #2 rst_i = 1;
        #1;
        n_tests++; if (bus.imem_req_o !== 1'b0 || inst_valid_o !== 1'b0 || pc_o !== 32'h0) begin
            n_fail++; $display("FAIL async_reset got req %b v %b pc %h want 0 0 0", bus.imem_req_o, inst_valid_o, pc_o);
        end
        model_reset();
        bus.imem_ack_i = 1;
        @(negedge clk_i);
        rst_i = 0;
        tick(0, 0, 0, 1);
        n_tests++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== RST_PC || inst_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL refetch got %b/%h/%b want 1/%h/0", bus.imem_req_o, bus.imem_addr_o, inst_valid_o, RST_PC);
        end
    endtask

    task automatic test_counters();
        logic [31:0] exp_f, exp_b;
        do_reset();
        tick(0, 0, 0, 0);
        for (int k = 0; k < 3; k++) tick(0, 0, 0, 0);
        for (int k = 0; k < 10; k++) tick(0, 0, 0, 1);
`ifdef FETCH_PERF_CNT_EN
        exp_f = 32'd10; exp_b = 32'd4;
`else
        exp_f = 32'd0; exp_b = 32'd0;
`endif
        n_tests++; if (fetch_cnt_o !== exp_f) begin n_fail++; $display("FAIL fetch_cnt got %0d want %0d", fetch_cnt_o, exp_f); end
        n_tests++; if (bubble_cnt_o !== exp_b) begin n_fail++; $display("FAIL bubble_cnt got %0d want %0d", bubble_cnt_o, exp_b); end
    endtask

    task automatic test_random();
        logic        s, b, a;
        logic [31:0] t, ef, eb;
        do_reset();
        for (int i = 0; i < 800; i++) begin
            s = ($urandom_range(0, 3) == 0);
            b = ($urandom_range(0, 11) == 0);
            a = ($urandom_range(0, 1) == 1);
            t = $urandom;
            tick(s, b, t, a);
`ifdef FETCH_PERF_CNT_EN
            ef = m_fc; eb = m_bc;
`else
            ef = 0; eb = 0;
`endif
            n_tests++;
            if (inst_o !== m_inst || pc_o !== m_pcq || inst_valid_o !== m_valid || bus.imem_req_o !== m_req ||
                (m_req && bus.imem_addr_o !== m_req_addr) || fetch_cnt_o !== ef || bubble_cnt_o !== eb) begin
                n_fail++;
                $display("FAIL random[%0d] got inst %h pc %h v %b req %b addr %h cnt %0d/%0d want %h %h %b %b %h %0d/%0d",
                         i, inst_o, pc_o, inst_valid_o, bus.imem_req_o, bus.imem_addr_o, fetch_cnt_o, bubble_cnt_o,
                         m_inst, m_pcq, m_valid, m_req, m_req_addr, ef, eb);
            end
        end
    endtask

    initial begin
        bus.imem_ack_i = 0;
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_stall_hold();
        test_branch_drain();
        test_wrap_and_async_reset();
        test_counters();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have port clk_i  input  1  clock; all state on rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port stall_i  input  1  hazard stall, the same signal that drives the IF/ID stall input.
REQ-005 SHALL have port branch_i  input  1  one-cycle redirect pulse from ID.
REQ-006 SHALL have port branch_target_i  input  32  redirect address; bits [1:0] forced to 0.
REQ-007 SHALL have port imem_req_o  output  1  instruction-memory request.
REQ-008 SHALL have port imem_addr_o  output  32  request address, word aligned.
REQ-009 SHALL have port imem_ack_i  input  1  read-data-valid strobe; may arrive in the request cycle.
REQ-010 SHALL have port imem_rdata_i  input  32  instruction word, valid when imem_ack_i=1.
REQ-011 SHALL have port inst_o  output  32  instruction to IF/ID; 32'h0 = bubble.
REQ-012 SHALL have port pc_o  output  32  address of inst_o.
REQ-013 SHALL have port inst_valid_o  output  1  inst_o holds a real instruction.
REQ-014 SHALL have port flush_o  output  1  IF/ID flush, combinationally equal to branch_i.
REQ-015 SHALL have ports fetch_cnt_o and bubble_cnt_o, both output, 32 bits each, performance counters (see Configuration).

Function
REQ-016 SHALL implement the states IDLE, FETCH, HOLD and DRAIN.
REQ-017 IDLE SHALL drive imem_req_o=0, ignore imem_ack_i, and go to FETCH on the next edge.
REQ-018 FETCH SHALL drive imem_req_o=1 with imem_addr_o = the latched request address; once raised, the request address SHALL stay stable until ack (no retraction).
REQ-019 On ack in FETCH with branch_i=0 and stall_i=0: inst_o<=rdata, pc_o<=request address, inst_valid_o<=1, PC<=PC+4, stay in FETCH; the new request SHALL appear the next cycle (1-cycle min latency, 1 instr/cycle with zero-wait memory).
REQ-020 On ack in FETCH with stall_i=1 and branch_i=0: the instruction and its PC SHALL be captured in a hold buffer; go to HOLD with imem_req_o=0.
REQ-021 HOLD with stall_i=1: outputs and buffer SHALL hold; when stall_i=0: buffer SHALL be loaded to the outputs (valid=1), PC<=PC+4, go to FETCH.
REQ-022 Any stall_i=0 cycle that loads no instruction SHALL load inst_o=32'h0 and inst_valid_o=0; pc_o holds.
REQ-023 While stall_i=1, inst_o, pc_o and inst_valid_o SHALL hold their values.
REQ-024 branch_i SHALL have priority over stall_i and ack: PC<=target, outputs<=bubble next edge.
REQ-025 On a branch in FETCH, the state transition SHALL depend on ack: with ack, the data is discarded and the state stays in FETCH at the target; without ack, the state goes to DRAIN.
REQ-026 On a branch in HOLD, the buffer SHALL be discarded and the state goes to FETCH at the target.
REQ-027 DRAIN SHALL keep imem_req_o=1 at the old address until ack, discard that data, then go to FETCH; a further branch in DRAIN only updates PC.
REQ-028 PC+4 SHALL wrap 32'hFFFF_FFFC -> 32'h0000_0000.

Reset
REQ-029 rst_i SHALL immediately force: IDLE, PC=RESET_PC, imem_req_o=0, inst_o=0, pc_o=0, inst_valid_o=0, counters=0.
REQ-030 Reset with an outstanding request SHALL abandon it; an ack arriving in IDLE SHALL be ignored.

Configuration
REQ-031 With FETCH_PERF_CNT_EN defined: fetch_cnt_o SHALL increment on each valid load and bubble_cnt_o on each bubble load, both wrapping at 2^32.
REQ-032 Without FETCH_PERF_CNT_EN: both ports SHALL remain present, constant 0, and no counter logic is present.

Verification
REQ-033 Zero-wait ack, RESET_PC=0x100 -> inst_o sequence at PCs 0x100, 0x104, 0x108 on consecutive cycles, valid=1.
REQ-034 Ack with 2 wait states -> req/addr stable 3 cycles, two bubbles precede each valid instruction.
REQ-035 stall_i high 3 cycles with ack in the first -> HOLD, outputs frozen, the instruction at PC 0x104 delivered on the cycle after release, no duplicate/loss.
REQ-036 branch_i to 0x2003 during an un-acked request -> flush_o=1 that cycle, DRAIN until ack, next request addr 0x2000, stale data never valid.
REQ-037 Async rst_i mid-request at PC 0xFFFF_FFFC then release -> req drops immediately, refetch at RESET_PC; separately, no reset -> wrap to 0x0.
REQ-038 With FETCH_PERF_CNT_EN, 10 valid + 4 bubble loads -> fetch_cnt_o=10, bubble_cnt_o=4; without -> both 0.
